audio_frame_fifo: RTL and testbench

APB-programmable, multichannel sample buffer for the audioport datapath. It is the parametrised successor to the single-frame `abuf_out` path. The CPU writes samples one channel at a time over APB. The block assembles them into frames, queues the frames in a DEPTH-entry FIFO and delivers one frame to the DSP side per `req_in` pulse while playing. It raises `irq_out` when the fill level drops to a programmable watermark and obeys START/STOP/CLR/IRQACK commands.

---
 rtl/audio_frame_fifo.sv | 235 +++++++++++++++++++++++
 tb/tb_audio_frame_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_fifo.sv
// APB-programmable multichannel sample buffer: assembles per-channel DATA writes
// into frames, queues them in a DEPTH-entry FIFO and plays one frame per req_in.
module audio_frame_fifo #(
    parameter int          CHANNELS  = 2,
    parameter int          SAMPLE_W  = 24,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [31:0]                  PADDR,
    input  logic [31:0]                  PWDATA,
    output logic [31:0]                  PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic                         req_in,
    output logic [CHANNELS*SAMPLE_W-1:0] abuf_out,
    output logic                         play_out,
    output logic                         irq_out,
    output logic                         clr_out
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam int              FW       = CHANNELS * SAMPLE_W;
    localparam logic [2:0]      LAST_CH  = 3'(CHANNELS - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [8:0]      DEPTH_X  = 9'(DEPTH);

    localparam logic [2:0] CMD_START  = 3'd1;
    localparam logic [2:0] CMD_STOP   = 3'd2;
    localparam logic [2:0] CMD_CLR    = 3'd3;
    localparam logic [2:0] CMD_IRQACK = 3'd4;

    typedef enum logic {
        STANDBY = 1'b0,
        PLAY    = 1'b1
    } state_t;

    state_t              state;
    logic                irq;
    logic                overflow;
    logic                underflow;
    logic [7:0]          wm;
    logic [2:0]          ch_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic [FW-1:0]       abuf_q;
    logic [FW-1:0]       push_frame;
    logic [SAMPLE_W-1:0] sample;
    logic [FW-1:0]       mem [DEPTH];
    logic [SAMPLE_W-1:0] slot [CHANNELS];

    // APB decode; the window is four words starting at BASE_ADDR
    logic [31:0] offset;
    logic        in_win;
    logic        apb_wr;
    logic        cmd_wr;
    logic        data_wr;
    logic        wm_wr;
    logic        cmd_start;
    logic        cmd_stop;
    logic        cmd_clr;
    logic        cmd_irqack;

    assign offset     = PADDR - BASE_ADDR;
    assign in_win     = (offset[31:4] == 28'd0);
    assign apb_wr     = PSEL & PENABLE & PWRITE & in_win;
    assign cmd_wr     = apb_wr && (offset[3:2] == 2'd0);
    assign data_wr    = apb_wr && (offset[3:2] == 2'd1);
    assign wm_wr      = apb_wr && (offset[3:2] == 2'd3);
    assign cmd_start  = cmd_wr && (PWDATA[2:0] == CMD_START);
    assign cmd_stop   = cmd_wr && (PWDATA[2:0] == CMD_STOP);
    assign cmd_clr    = cmd_wr && (PWDATA[2:0] == CMD_CLR);
    assign cmd_irqack = cmd_wr && (PWDATA[2:0] == CMD_IRQACK);
    assign sample     = PWDATA[SAMPLE_W-1:0];

    logic unused_apb;
    assign unused_apb = ^{PWDATA, offset[1:0]};

    // FIFO control: the pop always sees pre-cycle contents, so a pop frees
    // room for a push into a full FIFO but cannot rescue an empty one.
    logic clr_exec;
    logic pop_req;
    logic pop_valid;
    logic push_req;
    logic push_ok;
    logic empty;
    logic full;

    assign clr_exec   = cmd_clr && (state == STANDBY);
    assign pop_req    = req_in && (state == PLAY);
    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign pop_valid  = pop_req && !empty;
    assign push_req   = data_wr && (ch_ptr == LAST_CH);
    assign push_ok    = push_req && (!full || pop_valid);
    assign count_next = count + CW'(push_ok) - CW'(pop_valid);

    always_comb begin
        push_frame = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            push_frame[c*SAMPLE_W +: SAMPLE_W] = (ch_ptr == 3'(c)) ? sample : slot[c];
        end
    end

    // Watermark crossing; a watermark at or above DEPTH fires on any pop
    // that leaves room in the FIFO.
    logic [8:0] cnt_x;
    logic [8:0] cnt_next_x;
    logic [8:0] wm_x;
    logic       irq_set;
    logic       irq_clr;

    assign cnt_x      = 9'(count);
    assign cnt_next_x = 9'(count_next);
    assign wm_x       = {1'b0, wm};
    assign irq_set    = pop_req &&
                        (((cnt_x > wm_x) && (cnt_next_x <= wm_x)) ||
                         ((wm_x >= DEPTH_X) && (cnt_next_x < DEPTH_X)));
    assign irq_clr    = cmd_irqack || cmd_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= STANDBY;
            irq     <= 1'b0;
            clr_out <= 1'b0;
        end else begin
            clr_out <= clr_exec;
            case (state)
                STANDBY: if (cmd_start) state <= PLAY;
                PLAY:    if (cmd_stop)  state <= STANDBY;
                default: state <= STANDBY;
            endcase
            if (irq_clr) begin
                irq <= 1'b0;
            end else if (irq_set) begin
                irq <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ch_ptr    <= '0;
            abuf_q    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            wm        <= 8'(DEPTH / 2);
        end else begin
            if (wm_wr) begin
                wm <= PWDATA[7:0];
            end
            if (clr_exec) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                ch_ptr    <= '0;
                abuf_q    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (data_wr) begin
                    ch_ptr <= (ch_ptr == LAST_CH) ? 3'd0 : ch_ptr + 3'd1;
                end
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (push_req && !push_ok) begin
                    overflow <= 1'b1;
                end
                if (pop_req) begin
                    abuf_q <= pop_valid ? mem[rd_ptr] : '0;
                    if (!pop_valid) begin
                        underflow <= 1'b1;
                    end
                end
                if (pop_valid) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count_next;
            end
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (data_wr) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_ptr == 3'(c)) slot[c] <= sample;
            end
        end
        if (push_ok) begin
            mem[wr_ptr] <= push_frame;
        end
    end

    logic [31:0] status;

    always_comb begin
        status        = '0;
        status[0]     = (state == PLAY);
        status[1]     = irq;
        status[2]     = overflow;
        status[3]     = underflow;
        status[15:8]  = 8'(count);
        status[18:16] = ch_ptr;
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && in_win) begin
            case (offset[3:2])
                2'd2:    PRDATA = status;
                2'd3:    PRDATA = {24'd0, wm};
                default: PRDATA = '0;
            endcase
        end
    end

    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign abuf_out = abuf_q;
    assign play_out = (state == PLAY);
    assign irq_out  = irq & (state == PLAY);

endmodule

// File: tb/tb_audio_frame_fifo.sv
// Directed scoreboard bench for audio_frame_fifo: drivers queue expected frames and
// read data, a monitor pops and compares whenever the DUT presents them.
module tb_audio_frame_fifo;

    localparam int          CH    = 2;
    localparam int          SW    = 24;
    localparam int          DEPTH = 8;
    localparam int          FW    = CH * SW;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] A_CMD = BASE + 32'h0;
    localparam logic [31:0] A_DAT = BASE + 32'h4;
    localparam logic [31:0] A_STA = BASE + 32'h8;
    localparam logic [31:0] A_WM  = BASE + 32'hC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          PSEL = 1'b0;
    logic          PENABLE = 1'b0;
    logic          PWRITE = 1'b0;
    logic [31:0]   PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          req_in = 1'b0;
    logic [FW-1:0] abuf_out;
    logic          play_out;
    logic          irq_out;
    logic          clr_out;

    audio_frame_fifo #(
        .CHANNELS (CH),
        .SAMPLE_W (SW),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .req_in  (req_in),
        .abuf_out(abuf_out),
        .play_out(play_out),
        .irq_out (irq_out),
        .clr_out (clr_out)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard
    int            n_vec = 0;
    int            n_err = 0;
    logic [FW-1:0] exp_q[$];
    logic [31:0]   exp_rd_q[$];
    logic          req_seen = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void note_fail(string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no expectation queued, expected one at %0t", name, $time);
    endfunction

    always @(posedge clk) req_seen <= req_in;

    always @(negedge clk) begin
        check("pready", 64'(PREADY), 64'd1);
        check("pslverr", 64'(PSLVERR), 64'd0);
        if (!PSEL) check("prdata_idle", 64'(PRDATA), 64'd0);
        if (PSEL && PENABLE && !PWRITE) begin
            if (exp_rd_q.size() == 0) note_fail("prdata_q");
            else check("prdata", 64'(PRDATA), 64'(exp_rd_q.pop_front()));
        end
        if (req_seen && rst_n) begin
            if (exp_q.size() == 0) note_fail("abuf_q");
            else check("abuf", 64'(abuf_out), 64'(exp_q.pop_front()));
        end
    end

    // drivers: each starts and ends 1 time unit after a rising edge
    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        step(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        step(1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic req_pulse(input logic [FW-1:0] exp);
        exp_q.push_back(exp);
        req_in = 1'b1;
        step(1);
        req_in = 1'b0;
    endtask

    task automatic write_frame(input logic [23:0] c0, input logic [23:0] c1);
        apb_write(A_DAT, {8'd0, c0});
        apb_write(A_DAT, {8'd0, c1});
    endtask

    // DATA write whose access phase coincides with a req_in pulse
    task automatic write_with_req(input logic [23:0] d, input logic [FW-1:0] exp);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = A_DAT; PWDATA = {8'd0, d}; PENABLE = 1'b0;
        step(1);
        PENABLE = 1'b1;
        req_in = 1'b1;
        exp_q.push_back(exp);
        step(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; req_in = 1'b0;
    endtask

    initial begin
        // reset state
        step(2);
        check("rst_play", 64'(play_out), 64'd0);
        check("rst_irq", 64'(irq_out), 64'd0);
        check("rst_clr", 64'(clr_out), 64'd0);
        check("rst_abuf", 64'(abuf_out), 64'd0);
        rst_n = 1'b1;
        step(1);
        apb_read(A_STA, 32'h0000_0000);
        apb_read(A_WM, 32'h0000_0004);

        // fill and play
        apb_write(A_DAT, 32'h0011_1111);
        apb_write(A_DAT, 32'h0022_2222);
        apb_write(A_DAT, 32'h0033_3333);
        apb_read(A_STA, 32'h0001_0100);
        apb_write(A_DAT, 32'h0044_4444);
        apb_read(A_STA, 32'h0000_0200);
        apb_write(A_CMD, 32'd1);
        check("start_play", 64'(play_out), 64'd1);
        apb_read(A_STA, 32'h0000_0201);
        req_pulse(48'h222222_111111);
        req_pulse(48'h444444_333333);

        // watermark irq
        apb_write(A_WM, 32'd2);
        apb_read(A_WM, 32'd2);
        for (int k = 0; k < 4; k++) write_frame(24'h0A0000 + 24'(k), 24'h0B0000 + 24'(k));
        apb_write(A_CMD, 32'd1);
        req_pulse(48'h0B0000_0A0000);
        check("irq_pop1", 64'(irq_out), 64'd0);
        req_pulse(48'h0B0001_0A0001);
        check("irq_pop2", 64'(irq_out), 64'd1);
        apb_write(A_CMD, 32'd4);
        check("irq_ack", 64'(irq_out), 64'd0);
        apb_read(A_STA, 32'h0000_0201);

        // standby masking
        apb_write(A_WM, 32'd1);
        req_pulse(48'h0B0002_0A0002);
        check("irq_wm1", 64'(irq_out), 64'd1);
        apb_write(A_CMD, 32'd2);
        check("stop_irq", 64'(irq_out), 64'd0);
        check("stop_play", 64'(play_out), 64'd0);
        req_pulse(48'h0B0002_0A0002);
        apb_read(A_STA, 32'h0000_0100);

        // clear in standby, then ignored out-of-window writes
        apb_write(A_CMD, 32'd3);
        check("clr_pulse", 64'(clr_out), 64'd1);
        step(1);
        check("clr_end", 64'(clr_out), 64'd0);
        check("clr_abuf", 64'(abuf_out), 64'd0);
        apb_read(A_STA, 32'h0000_0000);
        apb_write(32'h0000_0200, 32'd1);
        apb_write(32'h0000_00FC, 32'd1);
        check("oow_write", 64'(play_out), 64'd0);

        // overflow then underflow
        for (int k = 0; k <= DEPTH; k++) write_frame(24'h000100 + 24'(k), 24'h000200 + 24'(k));
        apb_read(A_STA, 32'h0000_0804);
        apb_write(A_DAT, 32'h0000_0AAA);
        apb_read(A_STA, 32'h0001_0804);
        apb_write(A_DAT, 32'h0000_0BBB);
        apb_read(A_STA, 32'h0000_0804);
        apb_write(A_CMD, 32'd1);
        for (int k = 0; k < DEPTH; k++) req_pulse({24'h000200 + 24'(k), 24'h000100 + 24'(k)});
        req_pulse('0);
        apb_read(A_STA, 32'h0000_000F);

        // CLR in PLAY is ignored; STOP then CLR executes
        apb_write(A_CMD, 32'd3);
        check("clr_in_play", 64'(clr_out), 64'd0);
        apb_read(A_STA, 32'h0000_000F);
        apb_write(A_CMD, 32'd2);
        apb_write(A_CMD, 32'd3);
        check("clr2_pulse", 64'(clr_out), 64'd1);
        step(1);
        check("clr2_end", 64'(clr_out), 64'd0);
        apb_read(A_STA, 32'h0000_0000);

        // push and pop together on a full FIFO
        for (int k = 0; k < DEPTH; k++) write_frame(24'h000300 + 24'(k), 24'h000400 + 24'(k));
        apb_write(A_CMD, 32'd1);
        apb_write(A_DAT, 32'h0055_5555);
        write_with_req(24'h666666, 48'h000400_000300);
        apb_read(A_STA, 32'h0000_0801);
        for (int k = 1; k < DEPTH; k++) req_pulse({24'h000400 + 24'(k), 24'h000300 + 24'(k)});
        req_pulse(48'h666666_555555);

        // APB hygiene
        apb_read(A_CMD, 32'd0);
        apb_read(A_DAT, 32'd0);
        apb_read(32'h0000_0200, 32'd0);
        step(3);

        // reset mid-operation with a partial frame pending
        apb_write(A_DAT, 32'h0000_0777);
        rst_n = 1'b0;
        #2;
        check("rst2_play", 64'(play_out), 64'd0);
        check("rst2_abuf", 64'(abuf_out), 64'd0);
        check("rst2_irq", 64'(irq_out), 64'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        apb_read(A_STA, 32'h0000_0000);
        apb_read(A_WM, 32'h0000_0004);
        step(2);

        check("abuf_q_drained", 64'(exp_q.size()), 64'd0);
        check("rd_q_drained", 64'(exp_rd_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
